hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the five-stage core. Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers. It detects load-use hazards and inserts one-cycle bubbles into ID/EX, flushes IF/ID on taken branches, and sequences multi-cycle data-memory stalls through a request/acknowledge FSM that drives the common `memStall` freeze to every pipe register. It also keeps saturating performance counters and a sticky memory-timeout error flag.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter
- MEM_TIMEOUT, 1024, maximum cycles in MEM_WAIT before mem_err_o sets

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- id_rs_i  in  5  rs field of the instruction in ID
- id_rt_i  in  5  rt field of the instruction in ID
- idex_memread_i  in  1  MemRead held in ID/EX
- idex_rt_i  in  5  destination rt held in ID/EX
- branch_taken_i  in  1  branch in ID resolved taken
- dmem_req_i  in  1  MEM stage access outstanding; level, held until acknowledged
- dmem_ack_i  in  1  data memory completes the access this cycle
- pc_write_o  out  1  PC update enable
- ifid_write_o  out  1  IF/ID load enable
- ifid_flush_o  out  1  IF/ID zeroes its contents
- idex_bubble_o  out  1  ID/EX loads all-zero control signals
- mem_stall_o  out  1  freezes PC and all pipe registers
- stall_cnt_o  out  CNT_W  cycles with mem_stall_o high
- bubble_cnt_o  out  CNT_W  load-use bubbles inserted
- flush_cnt_o  out  CNT_W  IF/ID flushes issued
- mem_err_o  out  1  sticky memory-timeout flag

## Operation
- FSM states: RUN, MEM_WAIT.
  - RUN → MEM_WAIT when dmem_req_i=1 and dmem_ack_i=0.
  - MEM_WAIT → RUN on dmem_ack_i=1.
  - RUN with req and ack in the same cycle is a zero-wait hit: no stall, stay in RUN.
- mem_stall_o is combinational:
  - 1 in RUN when req=1 and ack=0.
  - 1 in MEM_WAIT when ack=0.
  - 0 otherwise.
- Load-use hazard: load_use = idex_memread_i and idex_rt_i≠0 and (idex_rt_i==id_rs_i or idex_rt_i==id_rt_i).
- Output priority is memory stall, then load-use, then branch:
  - mem_stall_o=1: pc_write_o=0, ifid_write_o=0, idex_bubble_o=0, ifid_flush_o=0. Everything freezes; bubbles and flushes are deferred, not lost.
  - load_use: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0. The branch is re-evaluated after the bubble.
  - branch_taken_i: ifid_flush_o=1, pc_write_o=1, ifid_write_o=1.
  - Otherwise: pc_write_o=1, ifid_write_o=1, others 0.
- Counters:
  - Each counter increments by 1 on a clock edge where its corresponding output is high.
  - Each counter saturates at all-ones and never wraps.
- Timeout:
  - An internal counter clears on entry to MEM_WAIT and increments each cycle in MEM_WAIT.
  - When it reaches MEM_TIMEOUT, mem_err_o sets.
  - mem_err_o clears only on reset. The FSM keeps waiting for ack.

## Timing
- Reset values:
  - State = RUN.
  - All counters = 0; mem_err_o = 0.
  - Outputs then follow the combinational rules: with inputs idle, pc_write_o=1, ifid_write_o=1, and all other outputs 0.
- Control outputs are combinational with zero latency. Counters, state and mem_err_o update on the posedge.
- A load-use bubble lasts exactly one cycle. On the next cycle ID/EX holds the bubble, so idex_memread_i=0 and the hazard clears.
- An N-cycle memory wait (ack arrives N cycles after req rises) gives exactly N stall cycles and stall_cnt_o += N.
- A reset asserted in MEM_WAIT returns the FSM to RUN immediately and drops mem_stall_o asynchronously.
- dmem_ack_i while dmem_req_i=0 is ignored.

## Structure
- A shared pipeline package holds:
  - the FSM state enum (RUN, MEM_WAIT);
  - REG_ZERO = 5'd0;
  - the default CNT_W.
- One sub-module, sat_counter (CNT_W, enable input), is instantiated three times for the performance counters.
- The timeout counter is inline.

## Test plan
- Load-use: idex_memread_i=1, idex_rt_i=5, id_rs_i=5.
  - Expect one cycle of idex_bubble_o=1, pc_write_o=0, ifid_write_o=0.
  - Expect bubble_cnt_o=1.
- Register zero: idex_rt_i=0=id_rs_i with memread=1 → no bubble.
- Memory wait: req high, ack after 3 cycles → mem_stall_o=1 for exactly 3 cycles, stall_cnt_o=3, state back in RUN.
- Zero-wait hit: req and ack in the same cycle → mem_stall_o never high, stall_cnt_o unchanged.
- Priority: mem stall, load-use and branch all together → only mem_stall_o asserted.
  - After ack, the bubble fires first.
  - Then the flush fires.
- Timeout: MEM_TIMEOUT=8, no ack → mem_err_o rises after 8 MEM_WAIT cycles and stays high after a later ack.
- Reset during MEM_WAIT → mem_stall_o=0 at once, all counters 0.
- Saturation: CNT_W=4 with 20 flushes → flush_cnt_o holds at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared pipeline definitions for the hazard/stall controller:
// FSM state encoding, the architectural zero register index, the default
// performance-counter width and the load-use detection helper.
package hazard_pkg;

  localparam int unsigned DEF_CNT_W = 32;
  localparam int unsigned REG_W     = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  // Load in ID/EX whose destination feeds a source of the instruction in ID.
  // Writes to the zero register never create a dependency.
  function automatic logic load_use_hit(input logic             memread,
                                        input logic [REG_W-1:0] ex_rt,
                                        input logic [REG_W-1:0] id_rs,
                                        input logic [REG_W-1:0] id_rt);
    return memread && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for performance statistics.
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-low reset, clears the count
//   en_i   count this cycle
//   cnt_o  current count, holds at all-ones
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  // Increment when enabled unless already saturated.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_o <= '0;
    end else if (en_i && (cnt_o != {CNT_W{1'b1}})) begin
      cnt_o <= cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the five-stage core.
// Detects load-use hazards (one-cycle ID/EX bubble), flushes IF/ID on taken
// branches and freezes the whole pipe while a data-memory access waits for
// its acknowledge. Keeps saturating stall/bubble/flush counters and a sticky
// memory-timeout flag.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low reset
//   id_rs_i, id_rt_i        source fields of the instruction in ID
//   idex_memread_i          MemRead held in ID/EX
//   idex_rt_i               load destination held in ID/EX
//   branch_taken_i          branch in ID resolved taken
//   dmem_req_i, dmem_ack_i  MEM stage request (level) and completion
//   pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, mem_stall_o
//                           combinational pipe controls
//   stall_cnt_o, bubble_cnt_o, flush_cnt_o  performance counters
//   mem_err_o               sticky memory-timeout flag
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned MEM_TIMEOUT = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             mem_stall_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             mem_err_o
);

  localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);

  state_e           state_q;
  state_e           state_d;
  logic [TMO_W-1:0] tmo_q;
  logic [TMO_W-1:0] tmo_inc;
  logic             load_use;

  assign load_use = load_use_hit(idex_memread_i, idex_rt_i, id_rs_i, id_rt_i);

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and pipe controls; memory stall outranks load-use outranks branch.
  // The stall is gated by reset so it drops the moment reset asserts.
  always_comb begin
    state_d       = state_q;
    mem_stall_o   = 1'b0;
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (dmem_req_i && !dmem_ack_i) begin
          state_d     = ST_MEM_WAIT;
          mem_stall_o = rst_i;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ack_i) begin
          state_d = ST_RUN;
        end else begin
          mem_stall_o = rst_i;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (mem_stall_o) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
    end else if (load_use) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      ifid_flush_o = 1'b1;
    end
  end

  // Saturating increment so a very long wait cannot wrap back below the limit.
  assign tmo_inc = (tmo_q == TMO_W'(MEM_TIMEOUT)) ? tmo_q : tmo_q + TMO_W'(1);

  // Wait-cycle counter: cleared on entry to MEM_WAIT, counts every MEM_WAIT cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tmo_q <= '0;
    end else if ((state_q == ST_RUN) && (state_d == ST_MEM_WAIT)) begin
      tmo_q <= '0;
    end else if (state_q == ST_MEM_WAIT) begin
      tmo_q <= tmo_inc;
    end
  end

  // Sticky timeout flag; the FSM keeps waiting for the acknowledge regardless.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_err_o <= 1'b0;
    end else if ((state_q == ST_MEM_WAIT) && (tmo_inc == TMO_W'(MEM_TIMEOUT))) begin
      mem_err_o <= 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (mem_stall_o),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (idex_bubble_o),
    .cnt_o (bubble_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (ifid_flush_o),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl with small counters and a short timeout.
// Each cycle the expected controls and counters are computed by a reference
// model, queued when the stimulus is driven, and compared at the negedge.
module tb_hazard_ctrl;

  localparam int unsigned CW   = 4;
  localparam int unsigned TMO  = 8;
  localparam int          CMAX = 15;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [4:0]    id_rs_i, id_rt_i, idex_rt_i;
  logic          idex_memread_i, branch_taken_i, dmem_req_i, dmem_ack_i;
  logic          pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, mem_stall_o;
  logic [CW-1:0] stall_cnt_o, bubble_cnt_o, flush_cnt_o;
  logic          mem_err_o;

  hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TMO)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .id_rs_i        (id_rs_i),
    .id_rt_i        (id_rt_i),
    .idex_memread_i (idex_memread_i),
    .idex_rt_i      (idex_rt_i),
    .branch_taken_i (branch_taken_i),
    .dmem_req_i     (dmem_req_i),
    .dmem_ack_i     (dmem_ack_i),
    .pc_write_o     (pc_write_o),
    .ifid_write_o   (ifid_write_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_bubble_o  (idex_bubble_o),
    .mem_stall_o    (mem_stall_o),
    .stall_cnt_o    (stall_cnt_o),
    .bubble_cnt_o   (bubble_cnt_o),
    .flush_cnt_o    (flush_cnt_o),
    .mem_err_o      (mem_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic pc, ifw, flush, bubble, stall, err;
    int   sc, bc, fc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state.
  bit m_wait;
  int m_tmo, m_sc, m_bc, m_fc;
  bit m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_tmo = 0; m_sc = 0; m_bc = 0; m_fc = 0; m_err = 0;
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // One cycle: drive at posedge+1, compare at negedge, advance model at posedge.
  task automatic step(input logic req, input logic ack, input logic mr,
                      input logic [4:0] xrt, input logic [4:0] rs,
                      input logic [4:0] rt, input logic br);
    exp_t e, o;
    bit   lu;
    dmem_req_i = req; dmem_ack_i = ack; idex_memread_i = mr;
    idex_rt_i = xrt; id_rs_i = rs; id_rt_i = rt; branch_taken_i = br;

    e.stall = m_wait ? !ack : (req && !ack);
    lu = mr && (xrt != 5'd0) && ((xrt == rs) || (xrt == rt));
    e.pc = 1; e.ifw = 1; e.bubble = 0; e.flush = 0;
    if (e.stall) begin
      e.pc = 0; e.ifw = 0;
    end else if (lu) begin
      e.pc = 0; e.ifw = 0; e.bubble = 1;
    end else if (br) begin
      e.flush = 1;
    end
    e.sc = m_sc; e.bc = m_bc; e.fc = m_fc; e.err = m_err;
    q.push_back(e);

    @(negedge clk_i);
    if (q.size() == 0) begin
      check_eq("queue_empty", 32'd1, 32'd0);
    end else begin
      o = q.pop_front();
      check_eq("mem_stall", 32'(mem_stall_o), 32'(o.stall));
      check_eq("pc_write", 32'(pc_write_o), 32'(o.pc));
      check_eq("ifid_write", 32'(ifid_write_o), 32'(o.ifw));
      check_eq("idex_bubble", 32'(idex_bubble_o), 32'(o.bubble));
      check_eq("ifid_flush", 32'(ifid_flush_o), 32'(o.flush));
      check_eq("stall_cnt", 32'(stall_cnt_o), 32'(o.sc));
      check_eq("bubble_cnt", 32'(bubble_cnt_o), 32'(o.bc));
      check_eq("flush_cnt", 32'(flush_cnt_o), 32'(o.fc));
      check_eq("mem_err", 32'(mem_err_o), 32'(o.err));
    end

    @(posedge clk_i);
    if (e.stall)  m_sc = sat(m_sc);
    if (e.bubble) m_bc = sat(m_bc);
    if (e.flush)  m_fc = sat(m_fc);
    if (m_wait) begin
      if (m_tmo < TMO) m_tmo = m_tmo + 1;
      if (m_tmo == TMO) m_err = 1;
      if (ack) m_wait = 0;
    end else if (req && !ack) begin
      m_wait = 1;
      m_tmo  = 0;
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  initial begin
    rst_i = 1'b0;
    dmem_req_i = 0; dmem_ack_i = 0; idex_memread_i = 0; idex_rt_i = 0;
    id_rs_i = 0; id_rt_i = 0; branch_taken_i = 0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check_eq("rst_pc_write", 32'(pc_write_o), 32'd1);
    check_eq("rst_ifid_write", 32'(ifid_write_o), 32'd1);
    check_eq("rst_stall", 32'(mem_stall_o), 32'd0);
    check_eq("rst_counters", 32'({stall_cnt_o, bubble_cnt_o, flush_cnt_o}), 32'd0);
    check_eq("rst_err", 32'(mem_err_o), 32'd0);
    rst_i = 1'b1;
    idle();

    // Load-use: exactly one bubble, then ID/EX holds the bubble.
    step(1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd9, 1'b0);
    idle();
    check_eq("bubble_cnt_one", 32'(bubble_cnt_o), 32'd1);
    // Match on rt field as well.
    step(1'b0, 1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b0);
    // Register zero never hazards.
    step(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    check_eq("regzero_bubble_cnt", 32'(bubble_cnt_o), 32'd2);

    // Memory wait: ack three cycles after req rises.
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    idle();
    check_eq("stall_cnt_three", 32'(stall_cnt_o), 32'd3);

    // Zero-wait hit, and a stray ack with no request.
    step(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    idle();
    check_eq("hit_stall_cnt", 32'(stall_cnt_o), 32'd3);

    // Priority: stall hides load-use and branch; bubble on ack, then flush.
    step(1'b1, 1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0, 1'b1);
    idle();
    check_eq("prio_bubble_cnt", 32'(bubble_cnt_o), 32'd3);
    check_eq("prio_flush_cnt", 32'(flush_cnt_o), 32'd1);

    // Timeout: entry cycle plus eight MEM_WAIT cycles.
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (7) step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check_eq("err_before_limit", 32'(mem_err_o), 32'd0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check_eq("err_at_limit", 32'(mem_err_o), 32'd1);
    step(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    idle();
    check_eq("err_sticky", 32'(mem_err_o), 32'd1);

    // Reset while in MEM_WAIT with the request still held.
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    #2 rst_i = 1'b0;
    #1;
    check_eq("rst_async_stall", 32'(mem_stall_o), 32'd0);
    check_eq("rst_async_counters", 32'({stall_cnt_o, bubble_cnt_o, flush_cnt_o}), 32'd0);
    check_eq("rst_async_err", 32'(mem_err_o), 32'd0);
    dmem_req_i = 1'b0;
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    model_reset();
    idle();

    // Saturation: 20 flushes on a 4-bit counter.
    repeat (20) step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    idle();
    check_eq("flush_saturate", 32'(flush_cnt_o), 32'd15);

    // Random traffic against the model; small register range to provoke hazards.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
